vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 29, vertical back porch
- HS_POL, 0, hsync asserted level
- VS_POL, 0, vsync asserted level
- PIPE, 0, timing-output delay in pixel ticks, legal range 0..7
- CW, 12, counter width
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, master clock
- clr, in, 1, reset; asynchronous, active-high
- pix_en, in, 1, pixel-tick enable (one-clk strobe at pixel rate)
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, pixel valid
- yvalid, out, 1, line in active region
- x, out, CW, horizontal counter
- y, out, CW, vertical counter
- line_start, out, 1, first pixel of every line
- frame_start, out, 1, first pixel of every frame
- frame_cnt, out, 16, completed-frame counter
REQ-003 Derived constants SHALL be H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP; every timing parameter SHALL be >=1 and both totals SHALL be <2^CW. Violations SHALL be elaboration errors.

Function
REQ-004 All state SHALL advance only on a posedge clk where pix_en=1; on any other edge all registers hold.
REQ-005 hc SHALL count 0..H_TOTAL-1 and wrap to 0. vc SHALL increment only on an hc wrap, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-006 x=hc and y=vc SHALL be driven directly from the counters, undelayed regardless of PIPE, for pixel-fetch addressing.
REQ-007 Raw decode of the line: active when hc<H_ACTIVE; hsync asserted when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC. The frame SHALL decode the same way with vc and the V_* parameters.
REQ-008 Raw yvalid SHALL be vc<V_ACTIVE. Raw de SHALL be the horizontal active AND yvalid.
REQ-009 Raw hsync SHALL be HS_POL when asserted, else ~HS_POL. vsync SHALL behave the same with VS_POL.
REQ-010 Raw line_start SHALL be (hc==0). Raw frame_start SHALL be (hc==0 && vc==0).
REQ-011 hsync, vsync, de, yvalid, line_start and frame_start SHALL be the raw decode delayed through a PIPE-stage shift register clocked per REQ-004. With PIPE=0 they SHALL be combinational from the counters.
REQ-012 line_start and frame_start outputs SHALL additionally be ANDed with pix_en, so each is exactly one clk wide.
REQ-013 frame_cnt SHALL increment by 1 (modulo 2^16) on the pixel tick where both hc and vc wrap to 0; it is undelayed.

Reset
REQ-014 While clr=1: hc, vc and frame_cnt SHALL be 0. Every pipe stage SHALL hold its inactive value (hsync=~HS_POL, vsync=~VS_POL, de=0, yvalid=0, line_start=0, frame_start=0).
REQ-015 With PIPE=0, de, yvalid and the start strobes decode counter (0,0) during reset, gated by REQ-012. The first pixel tick after release SHALL move hc to 1.
REQ-016 Asserting clr mid-frame SHALL abort the frame immediately with no partial frame_cnt increment.

Verification
REQ-017 Defaults, pix_en=1 every clk -> line period is 800 clk; hsync=0 exactly for hc 656..751; de=1 for hc 0..639 only while vc 0..479; frame period is 416800 clk.
REQ-018 Defaults -> vsync=0 exactly for vc 490..491; yvalid falls at vc=480; frame_cnt increments 0->1 at the hc=799,vc=520 tick.
REQ-019 PIPE=3 -> hsync, de and line_start edges lag the PIPE=0 edges by exactly 3 pixel ticks; x and y are unchanged versus PIPE=0.
REQ-020 pix_en every 4th clk -> counters and outputs hold between strobes; frame_start is high exactly 1 clk per frame; line period is 3200 clk.
REQ-021 clr pulse at hc=300,vc=200,frame_cnt=5 -> x=0, y=0, frame_cnt=0 and pipe outputs inactive within the same clk; counting restarts cleanly.
REQ-022 H=4/1/2/1, V=3/1/1/1, HS_POL=VS_POL=1 -> 8-tick lines and 6-line frames; hsync=1 at hc 5..6; vsync=1 at vc 4; wrap behaviour exact.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA-style raster timing generator: pixel/line counters, sync/active decode,
// optional PIPE-stage delay on the decoded timing, and a completed-frame count.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE     = 0,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          yvalid,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic VS_ON  = (VS_POL != 0);

  // Bad geometry must never elaborate into silently wrong timing.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("vga_timing_gen: every timing parameter must be >= 1");
  end
  if (CW < 1 || CW > 30 || H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit below 2**CW");
  end
  if (PIPE < 0 || PIPE > 7) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be in 0..7");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic yv;
    logic ls;
    logic fs;
  } tim_t;

  localparam tim_t TIM_IDLE = '{hs: ~HS_ON, vs: ~VS_ON, de: 1'b0, yv: 1'b0, ls: 1'b0, fs: 1'b0};

  logic [CW-1:0] hc, vc;
  logic          h_wrap, v_wrap;
  logic          h_act, h_sy, v_act, v_sy;
  tim_t          raw, tout;

  assign h_wrap = (hc == CW'(H_TOTAL - 1));
  assign v_wrap = (vc == CW'(V_TOTAL - 1));

  // Raster counters and frame count; everything advances only on a pixel tick.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hc        <= '0;
      vc        <= '0;
      frame_cnt <= '0;
    end else if (pix_en) begin
      hc <= h_wrap ? '0 : hc + 1'b1;
      if (h_wrap) begin
        vc <= v_wrap ? '0 : vc + 1'b1;
        if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign h_act = (hc < CW'(H_ACTIVE));
  assign h_sy  = (hc >= CW'(H_ACTIVE + H_FP)) && (hc < CW'(H_ACTIVE + H_FP + H_SYNC));
  assign v_act = (vc < CW'(V_ACTIVE));
  assign v_sy  = (vc >= CW'(V_ACTIVE + V_FP)) && (vc < CW'(V_ACTIVE + V_FP + V_SYNC));

  assign raw.hs = h_sy ? HS_ON : ~HS_ON;
  assign raw.vs = v_sy ? VS_ON : ~VS_ON;
  assign raw.yv = v_act;
  assign raw.de = h_act & v_act;
  assign raw.ls = (hc == '0);
  assign raw.fs = (hc == '0) && (vc == '0);

  if (PIPE == 0) begin : g_nopipe
    assign tout = raw;
  end else begin : g_pipe
    tim_t tim_pipe [PIPE];

    // Delay line for the decoded timing so it can line up with a pixel fetch pipeline.
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        for (int i = 0; i < PIPE; i++) tim_pipe[i] <= TIM_IDLE;
      end else if (pix_en) begin
        tim_pipe[0] <= raw;
        for (int i = 1; i < PIPE; i++) tim_pipe[i] <= tim_pipe[i-1];
      end
    end

    assign tout = tim_pipe[PIPE-1];
  end

  // Addresses stay undelayed; strobes are gated to a single clk per pixel tick.
  assign x           = hc;
  assign y           = vc;
  assign hsync       = tout.hs;
  assign vsync       = tout.vs;
  assign de          = tout.de;
  assign yvalid      = tout.yv;
  assign line_start  = tout.ls & pix_en;
  assign frame_start = tout.fs & pix_en;

endmodule
